mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have ports: Clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: Rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: Stall  in  1  hold stage contents.
REQ-004 SHALL have: Flush  in  1  load a bubble instead of incoming instruction.
REQ-005 SHALL have: InValid  in  1  incoming MEM-stage instruction valid.
REQ-006 SHALL have: InRegWr  in  1  incoming instruction writes a register.
REQ-007 SHALL have: InMemToReg  in  1  result from load data (1) or ALU (0).
REQ-008 SHALL have: InLoadType  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101-111 reserved.
REQ-009 SHALL have: InAddrLo  in  2  effective address bits [1:0].
REQ-010 SHALL have: InAluResult  in  32  ALU result.
REQ-011 SHALL have: InMemData  in  32  aligned data-memory word.
REQ-012 SHALL have: InRW  in  5  destination register.
REQ-013 SHALL have: BusW  out  32  write data to register file.
REQ-014 SHALL have: RW  out  5  write address to register file.
REQ-015 SHALL have: RegWr  out  1  register-file write enable (also used by forwarding unit).
REQ-016 SHALL have: RetireCount  out  32  count of retired instructions.
REQ-017 SHALL have: MisalignErr  out  1  sticky load-alignment/reserved-type error.

Function
REQ-018 SHALL hold state: valid_q, regwr_q, rw_q[4:0], data_q[31:0], bad_q, RetireCount, MisalignErr.
REQ-019 SHALL per rising edge apply priority Flush > Stall > capture.
REQ-020 Flush SHALL set valid_q=0 and regwr_q=0; other fields don't-care.
REQ-021 Stall (Flush low) SHALL hold all stage fields unchanged.
REQ-022 Capture SHALL load valid_q=InValid, regwr_q=InRegWr, rw_q=InRW, data_q=result per REQ-023..025, bad_q=alignment check per REQ-026.
REQ-023 InMemToReg=0: data_q=InAluResult.
REQ-024 InMemToReg=1, big-endian lanes (AddrLo 0 -> bits 31:24, 3 -> bits 7:0): lw = word; lh/lhu = halfword at AddrLo[1] (0 -> 31:16, 1 -> 15:0).
REQ-025 lb/lh sign-extend to 32 bits; lbu/lhu zero-extend.
REQ-026 bad=1 when InMemToReg=1 and (lw with AddrLo!=00, lh/lhu with AddrLo[0]=1, or reserved type); bad=0 when InMemToReg=0.
REQ-027 Outputs purely from registers: BusW=data_q, RW=rw_q, RegWr=valid_q & regwr_q & ~bad_q & (rw_q!=0).
REQ-028 Latency: inputs sampled at edge N appear on BusW/RW/RegWr after edge N; register file commits at edge N+1.
REQ-029 Writes to register 0 SHALL never assert RegWr.
REQ-030 Instruction SHALL retire on an edge where valid_q=1 and (Stall=0 or Flush=1); RetireCount increments by 1, wraps 0xFFFFFFFF -> 0.
REQ-031 Stalled instruction SHALL retire exactly once, regardless of stall length; RegWr remains asserted during stall (idempotent rewrite).
REQ-032 MisalignErr SHALL set on edge where captured bad=1 with InValid=1; cleared only by reset.
REQ-033 Flush with InValid=1 and bad inputs SHALL NOT set MisalignErr.

Reset
REQ-034 Rst low SHALL immediately, independent of Clk, force valid_q=0, regwr_q=0, rw_q=0, data_q=0, bad_q=0, RetireCount=0, MisalignErr=0; thus BusW=0, RW=0, RegWr=0.
REQ-035 Rst low mid-stall or mid-flush SHALL override all; first capture occurs on first rising edge with Rst high.

Verification
REQ-036 Capture InAluResult=0x12345678, InRW=5, InRegWr=1, InValid=1, InMemToReg=0 -> next cycle BusW=0x12345678, RW=5, RegWr=1; RetireCount 0->1 at following edge.
REQ-037 InMemData=0x80FF7F01: lb AddrLo=0 -> 0xFFFFFF80; lbu AddrLo=0 -> 0x00000080; lh AddrLo=2 -> 0x00007F01; lhu AddrLo=0 -> 0x000080FF; lb AddrLo=3 -> 0x00000001.
REQ-038 lw with AddrLo=2, InRW=8 -> RegWr=0, MisalignErr=1 and stays 1 through later valid loads until Rst low.
REQ-039 Valid write to InRW=0 -> RegWr=0, RetireCount still increments.
REQ-040 Valid instruction captured, Stall high 3 cycles, then low -> RegWr held 4 cycles, RetireCount increments once; Flush+Stall together -> bubble loaded, held instruction retires.
REQ-041 RetireCount preset via 2^32-1 retirements (or forced) then one retirement -> 0; Rst pulsed low mid-cycle -> all outputs 0 without clock edge.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: builds the load or ALU result, tracks retirement and flags misaligned loads.
// Latency: inputs captured at edge N drive BusW/RW/RegWr after edge N; the register file commits at edge N+1.
// Backpressure: Stall holds the stage (RegWr stays high, rewriting the same value); Flush beats Stall and inserts a bubble.
module mem_wb_stage (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        InValid,
  input  logic        InRegWr,
  input  logic        InMemToReg,
  input  logic [2:0]  InLoadType,
  input  logic [1:0]  InAddrLo,
  input  logic [31:0] InAluResult,
  input  logic [31:0] InMemData,
  input  logic [4:0]  InRW,
  output logic [31:0] BusW,
  output logic [4:0]  RW,
  output logic        RegWr,
  output logic [31:0] RetireCount,
  output logic        MisalignErr
);

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  logic        valid_q;
  logic        regwr_q;
  logic [4:0]  rw_q;
  logic [31:0] data_q;
  logic        bad_q;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] result;
  logic        bad_in;
  logic        capture;
  logic        retire;

  // Lane selection (big-endian: byte 0 is the top of the word), extension and alignment check.
  always_comb begin
    byte_sel  = 8'h00;
    half_sel  = 16'h0000;
    load_data = 32'h0000_0000;
    bad_in    = 1'b0;

    case (InAddrLo)
      2'd0:    byte_sel = InMemData[31:24];
      2'd1:    byte_sel = InMemData[23:16];
      2'd2:    byte_sel = InMemData[15:8];
      default: byte_sel = InMemData[7:0];
    endcase
    half_sel = InAddrLo[1] ? InMemData[15:0] : InMemData[31:16];

    case (InLoadType)
      LT_LW:   load_data = InMemData;
      LT_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  load_data = {16'h0000, half_sel};
      LT_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  load_data = {24'h00_0000, byte_sel};
      default: load_data = 32'h0000_0000;
    endcase

    if (InMemToReg) begin
      case (InLoadType)
        LT_LW:         bad_in = (InAddrLo != 2'b00);
        LT_LH, LT_LHU: bad_in = InAddrLo[0];
        LT_LB, LT_LBU: bad_in = 1'b0;
        default:       bad_in = 1'b1;
      endcase
    end

    result = InMemToReg ? load_data : InAluResult;
  end

  assign capture = ~Flush & ~Stall;
  // A held instruction retires once: on the edge that releases the stall or flushes it out.
  assign retire  = valid_q & (~Stall | Flush);

  // Stage register: Flush loads a bubble, Stall holds, otherwise capture the MEM-stage instruction.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      valid_q <= 1'b0;
      regwr_q <= 1'b0;
      rw_q    <= 5'd0;
      data_q  <= 32'h0000_0000;
      bad_q   <= 1'b0;
    end else if (Flush) begin
      valid_q <= 1'b0;
      regwr_q <= 1'b0;
    end else if (capture) begin
      valid_q <= InValid;
      regwr_q <= InRegWr;
      rw_q    <= InRW;
      data_q  <= result;
      bad_q   <= bad_in;
    end
  end

  // Retirement counter, wraps naturally at 2^32.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      RetireCount <= 32'h0000_0000;
    end else if (retire) begin
      RetireCount <= RetireCount + 32'd1;
    end
  end

  // Sticky error: only a real capture of a valid bad load sets it; flushed inputs never do.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      MisalignErr <= 1'b0;
    end else if (capture && InValid && bad_in) begin
      MisalignErr <= 1'b1;
    end
  end

  assign BusW  = data_q;
  assign RW    = rw_q;
  assign RegWr = valid_q & regwr_q & ~bad_q & (rw_q != 5'd0);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a driver pushes model predictions, a monitor compares after each edge.
module tb_mem_wb_stage;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Stall = 1'b0, Flush = 1'b0, InValid = 1'b0, InRegWr = 1'b0, InMemToReg = 1'b0;
  logic [2:0]  InLoadType = 3'd0;
  logic [1:0]  InAddrLo = 2'd0;
  logic [31:0] InAluResult = 32'd0, InMemData = 32'd0;
  logic [4:0]  InRW = 5'd0;
  logic [31:0] BusW;
  logic [4:0]  RW;
  logic        RegWr;
  logic [31:0] RetireCount;
  logic        MisalignErr;

  mem_wb_stage dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .InValid(InValid),
    .InRegWr(InRegWr), .InMemToReg(InMemToReg), .InLoadType(InLoadType),
    .InAddrLo(InAddrLo), .InAluResult(InAluResult), .InMemData(InMemData),
    .InRW(InRW), .BusW(BusW), .RW(RW), .RegWr(RegWr),
    .RetireCount(RetireCount), .MisalignErr(MisalignErr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit st, fl, v, rwr, mtr;
    logic [2:0]  lt;
    logic [1:0]  a;
    logic [31:0] alu, mem;
    logic [4:0]  rw;
  } stim_t;

  typedef struct {
    logic [31:0] busw;
    logic [4:0]  rw;
    logic        regwr;
    logic [31:0] cnt;
    logic        err;
    bit          dchk;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   armed = 0;
  bit   done = 0;

  // Reference model: the instruction sitting in the write-back slot plus the two counters.
  bit          m_valid, m_regwr, m_bad, m_err, m_dknown;
  logic [4:0]  m_rw;
  logic [31:0] m_data, m_cnt;

  function automatic logic [31:0] load_val(input logic [2:0] t, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] v;
    int unsigned sh;
    v = 32'd0;
    case (t)
      3'd0: v = w;
      3'd1, 3'd2: begin
        sh = a[1] ? 0 : 16;
        v = (w >> sh) & 32'h0000_FFFF;
        if (t == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      3'd3, 3'd4: begin
        sh = 8 * (3 - int'(a));
        v = (w >> sh) & 32'h0000_00FF;
        if (t == 3'd3 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  function automatic bit is_bad(input stim_t s);
    if (!s.mtr) return 0;
    if (s.lt == 3'd0) return s.a != 2'd0;
    if (s.lt == 3'd1 || s.lt == 3'd2) return s.a[0];
    if (s.lt == 3'd3 || s.lt == 3'd4) return 0;
    return 1;
  endfunction

  function automatic stim_t mk(input bit st, fl, v, rwr, mtr, input logic [2:0] lt, input logic [1:0] a,
                               input logic [31:0] alu, mem, input logic [4:0] rw);
    stim_t s;
    s.st = st; s.fl = fl; s.v = v; s.rwr = rwr; s.mtr = mtr;
    s.lt = lt; s.a = a; s.alu = alu; s.mem = mem; s.rw = rw;
    return s;
  endfunction

  task automatic mreset();
    m_valid = 0; m_regwr = 0; m_bad = 0; m_err = 0; m_dknown = 1;
    m_rw = 5'd0; m_data = 32'd0; m_cnt = 32'd0;
  endtask

  // Drive one cycle of inputs at a falling edge, predict the state after the next rising edge, push it.
  task automatic step(input stim_t s);
    exp_t e;
    Stall = s.st; Flush = s.fl; InValid = s.v; InRegWr = s.rwr; InMemToReg = s.mtr;
    InLoadType = s.lt; InAddrLo = s.a; InAluResult = s.alu; InMemData = s.mem; InRW = s.rw;
    if (!Rst) begin
      mreset();
    end else begin
      if (m_valid && (!s.st || s.fl)) m_cnt = m_cnt + 32'd1;
      if (s.fl) begin
        m_valid = 0; m_regwr = 0; m_dknown = 0;
      end else if (!s.st) begin
        m_valid  = s.v;
        m_regwr  = s.rwr;
        m_rw     = s.rw;
        m_bad    = is_bad(s);
        m_data   = s.mtr ? load_val(s.lt, s.a, s.mem) : s.alu;
        m_dknown = !m_bad;
        if (m_bad && s.v) m_err = 1;
      end
    end
    e.busw  = m_data;
    e.rw    = m_rw;
    e.regwr = m_valid && m_regwr && !m_bad && (m_rw != 5'd0);
    e.cnt   = m_cnt;
    e.err   = m_err;
    e.dchk  = m_dknown;
    q.push_back(e);
    @(negedge Clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busw"}, BusW, 32'd0);
    chk({nm, "_rw"}, {27'd0, RW}, 32'd0);
    chk({nm, "_regwr"}, {31'd0, RegWr}, 32'd0);
    chk({nm, "_cnt"}, RetireCount, 32'd0);
    chk({nm, "_err"}, {31'd0, MisalignErr}, 32'd0);
  endtask

  // Monitor: after every armed rising edge pop one prediction and compare every output.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (done) break;
      if (armed) begin
        if (q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL sb_empty: no prediction for edge at %0t", $time);
        end else begin
          e = q.pop_front();
          if (e.dchk) chk("sb_busw", BusW, e.busw);
          if (e.dchk) chk("sb_rw", {27'd0, RW}, {27'd0, e.rw});
          chk("sb_regwr", {31'd0, RegWr}, {31'd0, e.regwr});
          chk("sb_cnt", RetireCount, e.cnt);
          chk("sb_err", {31'd0, MisalignErr}, {31'd0, e.err});
        end
      end
    end
  end

  logic [2:0]  lt37   [5] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd3};
  logic [1:0]  a37    [5] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd3};
  logic [31:0] want37 [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7F01, 32'h0000_80FF, 32'h0000_0001};

  stim_t idle;
  stim_t rs;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 3'd0, 2'd0, 32'd0, 32'd0, 5'd0);
    mreset();
    #1;
    chk_all_zero("reset");
    @(negedge Clk);
    armed = 1;
    step(idle);
    Rst = 1'b1;

    // Basic ALU write-back and retirement one edge later.
    step(mk(0, 0, 1, 1, 0, 3'd0, 2'd0, 32'h1234_5678, 32'd0, 5'd5));
    chk("alu_busw", BusW, 32'h1234_5678);
    chk("alu_rw", {27'd0, RW}, 32'd5);
    chk("alu_regwr", {31'd0, RegWr}, 32'd1);
    chk("alu_cnt_before", RetireCount, 32'd0);
    step(idle);
    chk("alu_cnt_after", RetireCount, 32'd1);

    // Sub-word loads, lane selection and extension.
    for (int i = 0; i < 5; i++) begin
      step(mk(0, 0, 1, 1, 1, lt37[i], a37[i], 32'hDEAD_BEEF, 32'h80FF_7F01, 5'd7));
      chk($sformatf("load%0d_busw", i), BusW, want37[i]);
    end

    // Write to r0 never asserts RegWr but still retires.
    step(mk(0, 0, 1, 1, 0, 3'd0, 2'd0, 32'hAAAA_5555, 32'd0, 5'd0));
    chk("r0_regwr", {31'd0, RegWr}, 32'd0);

    // Stall for three cycles: RegWr stays high four cycles, one retirement.
    step(mk(0, 0, 1, 1, 0, 3'd0, 2'd0, 32'h0000_0042, 32'd0, 5'd9));
    chk("stall_regwr0", {31'd0, RegWr}, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      step(mk(1, 0, 1, 1, 0, 3'd0, 2'd0, 32'hFFFF_FFFF, 32'd0, 5'd3));
      chk($sformatf("stall_regwr%0d", i), {31'd0, RegWr}, 32'd1);
      chk($sformatf("stall_busw%0d", i), BusW, 32'h0000_0042);
    end
    step(idle);
    chk("stall_regwr_done", {31'd0, RegWr}, 32'd0);

    // Flush beats Stall: bubble loaded, held instruction retires.
    step(mk(0, 0, 1, 1, 0, 3'd0, 2'd0, 32'h0000_0077, 32'd0, 5'd4));
    step(mk(1, 1, 1, 1, 0, 3'd0, 2'd0, 32'h0000_0088, 32'd0, 5'd6));
    chk("flush_regwr", {31'd0, RegWr}, 32'd0);

    // Flushing a bad valid load must not raise the error.
    step(mk(0, 1, 1, 1, 1, 3'd0, 2'd2, 32'd0, 32'h1111_2222, 5'd8));
    chk("flush_bad_err", {31'd0, MisalignErr}, 32'd0);

    // Misaligned lw: no write, sticky error survives later good loads.
    step(mk(0, 0, 1, 1, 1, 3'd0, 2'd2, 32'd0, 32'h1111_2222, 5'd8));
    chk("mis_regwr", {31'd0, RegWr}, 32'd0);
    chk("mis_err", {31'd0, MisalignErr}, 32'd1);
    step(mk(0, 0, 1, 1, 1, 3'd0, 2'd0, 32'd0, 32'h3333_4444, 5'd8));
    step(mk(0, 0, 1, 1, 1, 3'd4, 2'd1, 32'd0, 32'h3333_4444, 5'd8));
    chk("mis_err_sticky", {31'd0, MisalignErr}, 32'd1);
    chk("mis_good_regwr", {31'd0, RegWr}, 32'd1);

    // Counter wrap: preload all-ones, then one retirement.
    step(mk(0, 0, 1, 1, 0, 3'd0, 2'd0, 32'h0BAD_F00D, 32'd0, 5'd2));
    force dut.RetireCount = 32'hFFFF_FFFF;
    #1;
    release dut.RetireCount;
    m_cnt = 32'hFFFF_FFFF;
    step(idle);
    chk("wrap_cnt", RetireCount, 32'd0);

    // Reset mid-cycle and mid-stall: outputs clear without a clock edge.
    step(mk(0, 0, 1, 1, 0, 3'd0, 2'd0, 32'h5A5A_5A5A, 32'd0, 5'd12));
    Rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    step(mk(1, 0, 1, 1, 0, 3'd0, 2'd0, 32'h6666_6666, 32'd0, 5'd13));
    Rst = 1'b1;
    step(mk(1, 1, 1, 1, 0, 3'd0, 2'd0, 32'h7777_7777, 32'd0, 5'd14));
    step(mk(0, 0, 1, 1, 0, 3'd0, 2'd0, 32'h8888_8888, 32'd0, 5'd15));
    chk("post_rst_capture", BusW, 32'h8888_8888);

    // Randomized traffic with an extra reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        Rst = 1'b0;
        #1;
        chk_all_zero("rand_rst");
        step(idle);
        Rst = 1'b1;
      end
      rs = mk($urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 8,
              $urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)));
      step(rs);
    end

    done = 1;
    #20;
    if (q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL sb_leftover: %0d predictions never checked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
